sparse_chunk_wr_assembler: RTL and testbench

Synthesizable write-side front end for the IFM and filter SRAMs. It sits directly downstream of the memory generator / DMA beat stream and consumes its per-cycle beats: sparse-map slice, compacted nonzero-data slice, valid, beat index and chunk index. It assembles WR_DAT_CYC_NUM beats into one full chunk, counts the chunk's nonzeros, and issues a single wide SRAM write per chunk. One instance is used per SRAM (IFM and filter).

---
 rtl/npu_mem_pkg.sv | 29 ++
 rtl/popcount.sv | 17 +
 rtl/sparse_chunk_wr_assembler.sv | 169 ++++++++++++++++
 tb/tb_sparse_chunk_wr_assembler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_mem_pkg.sv
// Shared NPU memory-path definitions: default geometry, slot/assembly states and the
// default-configuration chunk slot layout.
package npu_mem_pkg;

    localparam int unsigned NpuBusSize     = 32;
    localparam int unsigned NpuDatSize     = 8;
    localparam int unsigned NpuWrDatCycNum = 4;
    localparam int unsigned NpuChunkNum    = 16;

    typedef enum logic [1:0] {
        SlotEmpty,
        SlotFilling,
        SlotFull
    } slot_state_e;

    typedef enum logic {
        AsmIdle,
        AsmCollect
    } asm_state_e;

    typedef struct packed {
        logic [NpuBusSize*NpuWrDatCycNum-1:0]            map;
        logic [NpuBusSize*NpuWrDatCycNum*NpuDatSize-1:0] data;
        logic [$clog2(NpuChunkNum)-1:0]                  addr;
        logic [$clog2(NpuBusSize*NpuWrDatCycNum+1)-1:0]  nz_cnt;
        slot_state_e                                     state;
    } chunk_slot_t;

endpackage

// File: rtl/popcount.sv
// Combinational population count over a parameterised-width vector.
module popcount #(
    parameter int unsigned Width = 32,
    parameter int unsigned CntW  = $clog2(Width + 1)
) (
    input  logic [Width-1:0] data_i,
    output logic [CntW-1:0]  cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            cnt_o = cnt_o + CntW'(data_i[i]);
        end
    end

endmodule

// File: rtl/sparse_chunk_wr_assembler.sv
// Ping-pong chunk assembler: gathers WR_DAT_CYC_NUM beats into a chunk slot and issues one
// wide SRAM write per chunk while the other slot keeps filling.
module sparse_chunk_wr_assembler
    import npu_mem_pkg::*;
#(
    parameter int unsigned BUS_SIZE       = NpuBusSize,
    parameter int unsigned DAT_SIZE       = NpuDatSize,
    parameter int unsigned WR_DAT_CYC_NUM = NpuWrDatCycNum,
    parameter int unsigned CHUNK_NUM      = NpuChunkNum,
    parameter int unsigned DONE_CNT_W     = 16
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          clr_i,
    input  logic [BUS_SIZE-1:0]                           wr_sparsemap_i,
    input  logic [BUS_SIZE*DAT_SIZE-1:0]                  wr_nonzero_data_i,
    input  logic                                          wr_valid_i,
    input  logic [$clog2(WR_DAT_CYC_NUM)-1:0]             wr_dat_count_i,
    input  logic [$clog2(CHUNK_NUM)-1:0]                  wr_chunk_count_i,
    output logic                                          wr_ready_o,
    output logic                                          sram_wr_en_o,
    input  logic                                          sram_wr_ready_i,
    output logic [$clog2(CHUNK_NUM)-1:0]                  sram_wr_addr_o,
    output logic [BUS_SIZE*WR_DAT_CYC_NUM-1:0]            sram_wr_sparsemap_o,
    output logic [BUS_SIZE*WR_DAT_CYC_NUM*DAT_SIZE-1:0]   sram_wr_data_o,
    output logic [$clog2(BUS_SIZE*WR_DAT_CYC_NUM+1)-1:0]  sram_wr_nz_cnt_o,
    output logic                                          seq_err_o,
    output logic                                          ovf_err_o,
    output logic [DONE_CNT_W-1:0]                         chunk_done_cnt_o
);

    localparam int unsigned BeatW   = $clog2(WR_DAT_CYC_NUM);
    localparam int unsigned AddrW   = $clog2(CHUNK_NUM);
    localparam int unsigned MapW    = BUS_SIZE * WR_DAT_CYC_NUM;
    localparam int unsigned LaneW   = BUS_SIZE * DAT_SIZE;
    localparam int unsigned NzW     = $clog2(MapW + 1);
    localparam int unsigned BeatNzW = $clog2(BUS_SIZE + 1);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(WR_DAT_CYC_NUM - 1);

    typedef struct packed {
        logic [MapW-1:0]          map;
        logic [MapW*DAT_SIZE-1:0] data;
        logic [AddrW-1:0]         addr;
        logic [NzW-1:0]           nz_cnt;
        slot_state_e              state;
    } slot_t;

    slot_t [1:0]           slot_q, slot_d;
    logic                  fill_ptr_q, fill_ptr_d;
    logic                  drain_ptr_q, drain_ptr_d;
    asm_state_e            asm_q, asm_d;
    logic [BeatW-1:0]      exp_q, exp_d;
    logic                  seq_err_q, seq_err_d;
    logic                  ovf_err_q, ovf_err_d;
    logic [DONE_CNT_W-1:0] done_cnt_q, done_cnt_d;

    logic [BeatNzW-1:0] beat_nz;
    logic [BeatW-1:0]   exp_idx;
    logic               beat_accept;
    logic               drain_fire;
    logic               beat_in_seq;
    logic               beat_take;

    popcount #(
        .Width (BUS_SIZE),
        .CntW  (BeatNzW)
    ) u_beat_popcount (
        .data_i (wr_sparsemap_i),
        .cnt_o  (beat_nz)
    );

    assign wr_ready_o   = (slot_q[fill_ptr_q].state != SlotFull);
    assign beat_accept  = wr_valid_i & wr_ready_o;
    assign sram_wr_en_o = (slot_q[drain_ptr_q].state == SlotFull);
    assign drain_fire   = sram_wr_en_o & sram_wr_ready_i;

    assign sram_wr_addr_o      = slot_q[drain_ptr_q].addr;
    assign sram_wr_sparsemap_o = slot_q[drain_ptr_q].map;
    assign sram_wr_data_o      = slot_q[drain_ptr_q].data;
    assign sram_wr_nz_cnt_o    = slot_q[drain_ptr_q].nz_cnt;
    assign seq_err_o           = seq_err_q;
    assign ovf_err_o           = ovf_err_q;
    assign chunk_done_cnt_o    = done_cnt_q;

    // Outside a chunk only beat 0 is acceptable.
    assign exp_idx     = (asm_q == AsmCollect) ? exp_q : '0;
    assign beat_in_seq = (wr_dat_count_i == exp_idx);
    // An out-of-order beat 0 still opens a fresh chunk.
    assign beat_take   = beat_in_seq || (wr_dat_count_i == '0);

    always_comb begin
        slot_d      = slot_q;
        fill_ptr_d  = fill_ptr_q;
        drain_ptr_d = drain_ptr_q;
        asm_d       = asm_q;
        exp_d       = exp_q;
        seq_err_d   = seq_err_q;
        ovf_err_d   = ovf_err_q;
        done_cnt_d  = done_cnt_q;

        if (drain_fire) begin
            slot_d[drain_ptr_q].state = SlotEmpty;
            drain_ptr_d               = ~drain_ptr_q;
            done_cnt_d                = done_cnt_q + DONE_CNT_W'(1);
        end

        if (wr_valid_i && !wr_ready_o) begin
            ovf_err_d = 1'b1;
        end

        if (beat_accept) begin
            if (!beat_in_seq) begin
                seq_err_d                = 1'b1;
                slot_d[fill_ptr_q].state = SlotEmpty;
                asm_d                    = AsmIdle;
                exp_d                    = '0;
            end
            if (beat_take) begin
                slot_d[fill_ptr_q].map[wr_dat_count_i*BUS_SIZE +: BUS_SIZE] = wr_sparsemap_i;
                slot_d[fill_ptr_q].data[wr_dat_count_i*LaneW +: LaneW]      = wr_nonzero_data_i;
                if (wr_dat_count_i == '0) begin
                    slot_d[fill_ptr_q].addr   = wr_chunk_count_i;
                    slot_d[fill_ptr_q].nz_cnt = NzW'(beat_nz);
                end else begin
                    slot_d[fill_ptr_q].nz_cnt = slot_q[fill_ptr_q].nz_cnt + NzW'(beat_nz);
                end
                if (wr_dat_count_i == LastBeat) begin
                    slot_d[fill_ptr_q].state = SlotFull;
                    fill_ptr_d               = ~fill_ptr_q;
                    asm_d                    = AsmIdle;
                    exp_d                    = '0;
                end else begin
                    slot_d[fill_ptr_q].state = SlotFilling;
                    asm_d                    = AsmCollect;
                    exp_d                    = wr_dat_count_i + BeatW'(1);
                end
            end
        end

        if (clr_i) begin
            seq_err_d  = 1'b0;
            ovf_err_d  = 1'b0;
            done_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            slot_q      <= '0;
            fill_ptr_q  <= 1'b0;
            drain_ptr_q <= 1'b0;
            asm_q       <= AsmIdle;
            exp_q       <= '0;
            seq_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            slot_q      <= slot_d;
            fill_ptr_q  <= fill_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            asm_q       <= asm_d;
            exp_q       <= exp_d;
            seq_err_q   <= seq_err_d;
            ovf_err_q   <= ovf_err_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

endmodule

// File: tb/tb_sparse_chunk_wr_assembler.sv
// Randomised bench for sparse_chunk_wr_assembler against a queue-based model of the
// two-slot chunk buffer.
module tb_sparse_chunk_wr_assembler;

    localparam int unsigned Bus    = 32;
    localparam int unsigned Dat    = 8;
    localparam int unsigned Cyc    = 4;
    localparam int unsigned Chunks = 16;
    localparam int unsigned MapW   = Bus * Cyc;
    localparam int unsigned LaneW  = Bus * Dat;
    localparam int unsigned DataW  = MapW * Dat;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              clr_i = 1'b0;
    logic [Bus-1:0]    wr_sparsemap_i = '0;
    logic [LaneW-1:0]  wr_nonzero_data_i = '0;
    logic              wr_valid_i = 1'b0;
    logic [1:0]        wr_dat_count_i = '0;
    logic [3:0]        wr_chunk_count_i = '0;
    logic              wr_ready_o;
    logic              sram_wr_en_o;
    logic              sram_wr_ready_i = 1'b0;
    logic [3:0]        sram_wr_addr_o;
    logic [MapW-1:0]   sram_wr_sparsemap_o;
    logic [DataW-1:0]  sram_wr_data_o;
    logic [7:0]        sram_wr_nz_cnt_o;
    logic              seq_err_o;
    logic              ovf_err_o;
    logic [15:0]       chunk_done_cnt_o;

    always #5 clk_i = ~clk_i;

    sparse_chunk_wr_assembler #(
        .BUS_SIZE       (Bus),
        .DAT_SIZE       (Dat),
        .WR_DAT_CYC_NUM (Cyc),
        .CHUNK_NUM      (Chunks),
        .DONE_CNT_W     (16)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .clr_i               (clr_i),
        .wr_sparsemap_i      (wr_sparsemap_i),
        .wr_nonzero_data_i   (wr_nonzero_data_i),
        .wr_valid_i          (wr_valid_i),
        .wr_dat_count_i      (wr_dat_count_i),
        .wr_chunk_count_i    (wr_chunk_count_i),
        .wr_ready_o          (wr_ready_o),
        .sram_wr_en_o        (sram_wr_en_o),
        .sram_wr_ready_i     (sram_wr_ready_i),
        .sram_wr_addr_o      (sram_wr_addr_o),
        .sram_wr_sparsemap_o (sram_wr_sparsemap_o),
        .sram_wr_data_o      (sram_wr_data_o),
        .sram_wr_nz_cnt_o    (sram_wr_nz_cnt_o),
        .seq_err_o           (seq_err_o),
        .ovf_err_o           (ovf_err_o),
        .chunk_done_cnt_o    (chunk_done_cnt_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: completed chunks wait in order; the source can push while fewer than two wait.
    typedef struct {
        logic [MapW-1:0]  map;
        logic [DataW-1:0] data;
        int               addr;
        int               nz;
    } chunk_t;

    chunk_t pend[$];
    chunk_t cur;
    int     m_exp;
    bit     m_seq;
    bit     m_ovf;
    int     m_done;

    function automatic void model_reset();
        pend.delete();
        cur.map  = '0;
        cur.data = '0;
        cur.addr = 0;
        cur.nz   = 0;
        m_exp    = 0;
        m_seq    = 1'b0;
        m_ovf    = 1'b0;
        m_done   = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [Bus-1:0] mp,
                                       input logic [LaneW-1:0] dt, input int idx, input int ch,
                                       input bit srdy, input bit clr);
        bit rdy  = (pend.size() < 2);
        bit take = (idx == m_exp) || (idx == 0);
        if (pend.size() > 0 && srdy) begin
            void'(pend.pop_front());
            m_done = (m_done + 1) % 65536;
        end
        if (v && !rdy) m_ovf = 1'b1;
        if (v && rdy) begin
            if (idx != m_exp) begin
                m_seq = 1'b1;
                m_exp = 0;
            end
            if (take) begin
                if (idx == 0) begin
                    cur.map  = '0;
                    cur.data = '0;
                    cur.addr = ch;
                    cur.nz   = 0;
                end
                cur.map[idx*Bus +: Bus]      = mp;
                cur.data[idx*LaneW +: LaneW] = dt;
                cur.nz += $countones(mp);
                if (idx == Cyc - 1) begin
                    pend.push_back(cur);
                    m_exp = 0;
                end else begin
                    m_exp = idx + 1;
                end
            end
        end
        if (clr) begin
            m_seq  = 1'b0;
            m_ovf  = 1'b0;
            m_done = 0;
        end
    endfunction

    task automatic check_outputs();
        chk("wr_ready", wr_ready_o, pend.size() < 2);
        chk("wr_en", sram_wr_en_o, pend.size() > 0);
        chk("seq_err", seq_err_o, m_seq);
        chk("ovf_err", ovf_err_o, m_ovf);
        chk("done_cnt", chunk_done_cnt_o, m_done);
        if (pend.size() > 0) begin
            chk("wr_addr", sram_wr_addr_o, pend[0].addr);
            chk("nz_cnt", sram_wr_nz_cnt_o, pend[0].nz);
            chk("wr_map", sram_wr_sparsemap_o, pend[0].map);
            for (int k = 0; k < Cyc; k++) begin
                chk("wr_data", sram_wr_data_o[k*LaneW +: LaneW], pend[0].data[k*LaneW +: LaneW]);
            end
        end
    endtask

    function automatic logic [LaneW-1:0] rand_lane();
        logic [LaneW-1:0] r;
        for (int i = 0; i < LaneW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Called just after a rising edge; checks before the next edge, then advances the model.
    task automatic step(input bit v, input logic [Bus-1:0] mp, input logic [LaneW-1:0] dt,
                        input int idx, input int ch, input bit srdy, input bit clr);
        wr_valid_i        = v;
        wr_sparsemap_i    = mp;
        wr_nonzero_data_i = dt;
        wr_dat_count_i    = 2'(idx);
        wr_chunk_count_i  = 4'(ch);
        sram_wr_ready_i   = srdy;
        clr_i             = clr;
        @(negedge clk_i);
        check_outputs();
        model_step(v, mp, dt, idx, ch, srdy, clr);
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input int idx, input int ch, input logic [Bus-1:0] mp, input bit srdy);
        step(1'b1, mp, rand_lane(), idx, ch, srdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit srdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 0, 0, srdy, 1'b0);
    endtask

    task automatic reset_dut();
        rst_i           = 1'b0;
        wr_valid_i      = 1'b0;
        clr_i           = 1'b0;
        sram_wr_ready_i = 1'b0;
        #2;
        chk("rst_en", sram_wr_en_o, 0);
        chk("rst_addr", sram_wr_addr_o, 0);
        chk("rst_map", sram_wr_sparsemap_o, 0);
        chk("rst_data", sram_wr_data_o[LaneW-1:0], 0);
        chk("rst_nz", sram_wr_nz_cnt_o, 0);
        chk("rst_seq", seq_err_o, 0);
        chk("rst_ovf", ovf_err_o, 0);
        chk("rst_done", chunk_done_cnt_o, 0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_ready", wr_ready_o, 1);
    endtask

    task automatic random_run(input int cycles);
        int src = 0;
        int idx;
        bit v, srdy, clr, acc;
        for (int n = 0; n < cycles; n++) begin
            v    = ($urandom_range(0, 3) != 0);
            idx  = src;
            if ($urandom_range(0, 15) == 0) idx = $urandom_range(0, Cyc - 1);
            srdy = ($urandom_range(0, 9) < 6);
            clr  = ($urandom_range(0, 63) == 0);
            acc  = v && (pend.size() < 2);
            step(v, $urandom() & $urandom(), rand_lane(), idx, $urandom_range(0, Chunks - 1),
                 srdy, clr);
            if (acc) src = (idx + 1) % Cyc;
        end
    endtask

    initial begin
        int src;
        model_reset();
        #3;
        reset_dut();

        // Single chunk to address 5, held until the SRAM accepts.
        for (int k = 0; k < Cyc; k++) beat(k, 5, 32'h0000_000F, 1'b0);
        chk("single_en", sram_wr_en_o, 1);
        chk("single_addr", sram_wr_addr_o, 5);
        chk("single_nz", sram_wr_nz_cnt_o, 16);
        idle(2, 1'b1);
        chk("single_done", chunk_done_cnt_o, 1);

        // Back-to-back chunks at full rate.
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < Cyc; k++) beat(k, c, $urandom(), 1'b1);
        end
        idle(2, 1'b1);
        chk("b2b_done", chunk_done_cnt_o, 9);
        chk("b2b_seq", seq_err_o, 0);
        chk("b2b_ovf", ovf_err_o, 0);

        // Backpressure: stream while the SRAM stalls.
        src = 0;
        for (int n = 0; n < 12; n++) begin
            bit acc = (pend.size() < 2);
            beat(src, 12 + (n % 4), $urandom(), 1'b0);
            if (acc) src = (src + 1) % Cyc;
        end
        chk("bp_ovf", ovf_err_o, 1);
        chk("bp_ready", wr_ready_o, 0);
        idle(6, 1'b1);

        // Sequence error then a clean chunk.
        step(1'b0, '0, '0, 0, 0, 1'b1, 1'b1);
        beat(0, 3, $urandom(), 1'b1);
        beat(1, 3, $urandom(), 1'b1);
        beat(3, 3, $urandom(), 1'b1);
        chk("seq_set", seq_err_o, 1);
        chk("seq_nowrite", sram_wr_en_o, 0);
        for (int k = 0; k < Cyc; k++) beat(k, 9, $urandom(), 1'b1);
        idle(2, 1'b1);
        chk("seq_done", chunk_done_cnt_o, 1);

        // Reset mid-chunk, then a fresh chunk.
        for (int k = 0; k < 3; k++) beat(k, 7, $urandom(), 1'b1);
        reset_dut();
        for (int k = 0; k < Cyc; k++) beat(k, 14, $urandom(), 1'b0);
        chk("post_rst_addr", sram_wr_addr_o, 14);

        // Clear after errors while a write is held.
        beat(2, 0, $urandom(), 1'b0);
        chk("pre_clr_seq", seq_err_o, 1);
        step(1'b0, '0, '0, 0, 0, 1'b0, 1'b1);
        chk("clr_seq", seq_err_o, 0);
        chk("clr_ovf", ovf_err_o, 0);
        chk("clr_done", chunk_done_cnt_o, 0);
        chk("clr_hold_en", sram_wr_en_o, 1);
        chk("clr_hold_addr", sram_wr_addr_o, 14);
        idle(2, 1'b1);
        chk("clr_then_done", chunk_done_cnt_o, 1);

        random_run(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
